// File: rtl/mux_nx1_rr_pkg.sv
// Shared definitions for the N-to-1 registered mux:
// mode encodings and the per-channel bus slice helper.
package mux_nx1_rr_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Low bit of channel idx inside a packed N*width bus.
   function automatic int chan_lo(input int idx,
                                  input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest set req bit at or above ptr, wrapping.
// Ports: req[N], ptr[SW] in; grant[N] one-hot or zero, grant_idx[SW] out.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [SW-1:0] grant_idx
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] mask;
   logic [2*N-1:0] hit;

   // Two copies of req: the upper copy supplies the wrapped
   // channels once everything below ptr has been masked off.
   assign dbl  = {req, req};
   assign mask = {2*N{1'b1}} << ptr;
   assign hit  = dbl & mask;

   // Scan from the top down so the lowest hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      for (int i = 2*N-1; i >= 0; i--) begin
         if (hit[i]) begin
            grant          = '0;
            grant[i % N]   = 1'b1;
            grant_idx      = SW'(i % N);
         end
      end
   end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-to-1 registered mux, fixed-select or round-robin, valid/ready on all sides.
// Ports: clk, rst (async high); in_data/in_valid/in_ready[N]; mode, sel; out_data/out_src/out_valid/out_ready.
module mux_nx1_rr
   import mux_nx1_rr_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SW    = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]     in_valid,
   output logic [N-1:0]     in_ready,
   input  logic             mode,
   input  logic [SW-1:0]    sel,
   output logic [WIDTH-1:0] out_data,
   output logic [SW-1:0]    out_src,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [N-1:0]     fix_grant;
   logic [N-1:0]     rr_grant;
   logic [N-1:0]     grant;
   logic [SW-1:0]    rr_idx;
   logic [SW-1:0]    gidx;
   logic [SW-1:0]    ptr;
   logic [SW-1:0]    next_ptr;
   logic [WIDTH-1:0] sel_data;
   logic             can_load;
   logic             in_xfer;

   // Out-of-range sel matches no channel, so nothing is granted.
   always_comb begin
      fix_grant = '0;
      for (int i = 0; i < N; i++) begin
         if (sel == SW'(i)) begin
            fix_grant[i] = in_valid[i];
         end
      end
   end

   rr_arbiter #(
      .N  (N),
      .SW (SW)
   ) u_arb (
      .req       (in_valid),
      .ptr       (ptr),
      .grant     (rr_grant),
      .grant_idx (rr_idx)
   );

   always_comb begin
      grant = '0;
      gidx  = '0;
      unique case (mode)
         MODE_FIXED: begin
            grant = fix_grant;
            gidx  = sel;
         end
         MODE_RR: begin
            grant = rr_grant;
            gidx  = rr_idx;
         end
      endcase
   end

   // out_ready reaches in_ready combinationally so a full
   // register can drain and reload on the same edge.
   assign can_load = ~out_valid | out_ready;
   assign in_ready = grant & {N{can_load}};
   assign in_xfer  = |(in_valid & in_ready);

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gidx == SW'(i)) begin
            sel_data = in_data[chan_lo(i, WIDTH) +: WIDTH];
         end
      end
   end

   // Explicit wrap since N need not be a power of two.
   assign next_ptr = (gidx == SW'(N-1)) ? '0
                                        : gidx + SW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         ptr       <= '0;
      end else begin
         if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= gidx;
            if (mode == MODE_RR) begin
               ptr <= next_ptr;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
